// File: rtl/inst_fetch_responder.sv
// Instruction-memory responder for the fetch port: valid/ready request in, registered
// instruction out after LATENCY cycles, with misalignment/range error flagging.
module inst_fetch_responder #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned           LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_inst,
    output logic                  resp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [31:0]           ld_data,
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           err_cnt
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("inst_fetch_responder: LATENCY must be in 1..15");
    end

    localparam int unsigned           DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0]            LAT_M1 = 4'(LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(4) << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              lat_q, lat_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             inst_q, inst_d;
    logic                    err_q, err_d;
    logic [31:0]             fcnt_q, fcnt_d;
    logic [31:0]             ecnt_q, ecnt_d;

    logic [31:0]             mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   off;
    logic                    addr_err;
    logic [DEPTH_LOG2-1:0]   idx;

    always_comb begin
        off      = addr_q - BASE_ADDR;
        addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (off >= SPAN);
        idx      = off[DEPTH_LOG2+1:2];
    end

    // Acceptance always passes through WAIT (lat_cnt = LATENCY-1 counted down to 0), so the
    // array read lands on the edge exactly LATENCY cycles after acceptance.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    lat_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == 4'd0) begin
                    inst_d  = addr_err ? '0 : mem[idx];
                    err_d   = addr_err;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    fcnt_d  = fcnt_q + 32'd1;
                    if (err_q) ecnt_d = ecnt_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // Loader port is independent of reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_inst  = inst_q;
    assign resp_err   = err_q;
    assign fetch_cnt  = fcnt_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench for inst_fetch_responder: driver pushes expected responses from a
// word-array reference model; a negedge monitor pops and compares on each response.
module tb_inst_fetch_responder;

    localparam int unsigned     AW    = 64;
    localparam int unsigned     DL2   = 12;
    localparam int unsigned     LAT   = 4;
    localparam logic [63:0]     BASE  = 64'h8000_0000;
    localparam logic [63:0]     DEPTH = 64'd1 << DL2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        ld_en = 1'b0;
    logic [11:0] ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] fetch_cnt;
    logic [31:0] err_cnt;

    inst_fetch_responder #(
        .ADDR_WIDTH(AW),
        .DEPTH_LOG2(DL2),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_inst (resp_inst),
        .resp_err  (resp_err),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .fetch_cnt (fetch_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [int];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rr_mode = 0;
    logic [31:0] exp_fetch = '0;
    logic [31:0] exp_err = '0;
    bit          seen = 1'b0;
    bit          post_rst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // resp_ready policy: 0 = always ready, 1 = stalled, else random back-pressure
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'b0;
            default: resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    function automatic exp_t ref_fetch(input logic [63:0] a);
        exp_t e;
        e.err  = (a % 64'd4 != 64'd0) || (a < BASE) || ((a - BASE) >= 64'd4 * DEPTH);
        e.inst = e.err ? 32'h0 : mdl[int'((a - BASE) / 64'd4)];
        e.acc  = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_fetch = '0;
            exp_err   = '0;
            seen      = 1'b0;
            post_rst  = 1'b1;
        end else begin
            if (post_rst) begin
                chk("rst_req_ready", req_ready, 1);
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_resp_inst", resp_inst, 0);
                chk("rst_resp_err", resp_err, 0);
                chk("rst_fetch_cnt", fetch_cnt, 0);
                chk("rst_err_cnt", err_cnt, 0);
                post_rst = 1'b0;
            end
            chk("fetch_cnt", fetch_cnt, exp_fetch);
            chk("err_cnt", err_cnt, exp_err);
            chk("req_ready", req_ready, sb.size() == 0);
            if (sb.size() == 0) begin
                chk("spurious_resp_valid", resp_valid, 0);
            end else if (resp_valid) begin
                if (!seen) chk("latency", cyc, sb[0].acc + LAT);
                seen = 1'b1;
                chk("resp_inst", resp_inst, sb[0].inst);
                chk("resp_err", resp_err, sb[0].err);
                if (resp_ready) begin
                    exp_fetch++;
                    if (sb[0].err) exp_err++;
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end else if (!seen && cyc >= sb[0].acc + LAT) begin
                chk("late_resp_valid", resp_valid, 1);
                seen = 1'b1;
            end
        end
    end

    task automatic ld(input int idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_idx  = idx[11:0];
        ld_data = d;
        mdl[idx] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a);
        exp_t e;
        int   n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready 0 for addr %0h, required 1", a);
            req_valid = 1'b0;
            return;
        end
        e = ref_fetch(a);
        @(posedge clk); #1;
        e.acc = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int unsigned sel;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        ld(0, 32'h0010_0093);
        ld(1, 32'h0000_0073);
        ld(2, 32'h1111_1111);
        for (int i = 3; i < 64; i++) ld(i, $urandom);
        ld(4095, $urandom);

        fetch(BASE);
        fetch(BASE + 64'h4);
        fetch(BASE + 64'h8);
        fetch(BASE + 64'h3FFC);
        wait_idle();

        fetch(BASE + 64'h2);
        fetch(64'h7FFF_FFFC);
        fetch(BASE + 64'h4000);
        wait_idle();
        chk("err_cnt_after_bad", err_cnt, 3);
        chk("fetch_cnt_after_bad", fetch_cnt, 7);

        // Stall in RESP with a competing request that must wait for IDLE
        rr_mode = 1;
        @(posedge clk); #1;
        fetch(BASE + 64'h4);
        req_valid = 1'b1;
        req_addr  = BASE;
        repeat (15) begin @(posedge clk); #1; end
        rr_mode = 0;
        fetch(BASE);
        wait_idle();

        // Loader write lands on the array-read edge: old word returned
        fetch(BASE + 64'h8);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        ld(2, 32'hDEAD_BEEF);
        wait_idle();
        fetch(BASE + 64'h8);
        wait_idle();

        // Reset mid-WAIT
        fetch(BASE + 64'h4);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        fetch(BASE);
        wait_idle();

        // Reset on the handshake edge
        fetch(BASE);
        repeat (LAT) begin @(posedge clk); #1; end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        fetch(BASE + 64'h4);
        wait_idle();

        rr_mode = 2;
        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4, 5: a = BASE + 64'd4 * $urandom_range(0, 63);
                6:                a = BASE + 64'h3FFC;
                7:                a = BASE + 64'd4 * $urandom_range(0, 63) + $urandom_range(1, 3);
                8:                a = BASE - 64'd4 * $urandom_range(1, 1000);
                default:          a = (k % 2 == 0) ? BASE + 64'h4000 + 64'd4 * $urandom_range(0, 1000)
                                                   : 64'hFFFF_FFFF_FFFF_FFFC;
            endcase
            fetch(a);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        rr_mode = 0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
